instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage of the RV32I core, directly upstream of the control unit. Holds the PC, issues word fetches to instruction memory over a req/ready + rvalid handshake, buffers each returned word and presents it to decode with a valid/ready handshake. Its `id_opcode` output drives the control unit's opcode input. Taken branch/jump targets arrive as a redirect; a redirect squashes any in-flight or buffered instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, always word-aligned.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid; exactly one per accepted request, at least 1 cycle after acceptance.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  taken branch/jump this cycle.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored and treated as 00.
- `id_valid`  out  1  decode-side instruction valid.
- `id_ready`  in  1  decode consumes the instruction.
- `id_instr`  out  32  buffered instruction.
- `id_pc`  out  32  PC of `id_instr`.
- `id_opcode`  out  7  `id_instr[6:0]`, to control unit.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DROP. At most one outstanding memory request.
- IDLE: entered on reset; next cycle goes to REQ. `imem_req`=0.
- REQ: `imem_req`=1, `imem_addr`=pc. On `imem_ready`, go to WAIT. The memory samples the address only on a req&&ready cycle, so the address may change while req stays high.
- WAIT: `imem_req`=0. On `imem_rvalid`, load `id_instr`<=rdata and `id_pc`<=pc, then go to HOLD.
- HOLD: `id_valid`=1. On `id_valid && id_ready`, set pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0) and go to REQ.
- DROP: waits for the response of a squashed request. On `imem_rvalid`, discard the data and go to REQ.
- Redirect has priority over every other event. It always sets pc<={redirect_pc[31:2],2'b00}. Next state per current state:
  - IDLE/REQ without `imem_ready`: REQ.
  - REQ with `imem_ready` in the same cycle: DROP (the old address was accepted).
  - WAIT without `imem_rvalid`: DROP.
  - WAIT with `imem_rvalid` in the same cycle: REQ; the data is discarded.
  - HOLD: REQ; the buffer is invalidated. A coincident `id_ready` handshake is still counted by decode, but the fetch unit does not add 4 to the PC.
  - DROP without `imem_rvalid`: stays DROP. DROP with `imem_rvalid`: REQ.
- `imem_rvalid` in IDLE, REQ or HOLD is a protocol error and is ignored.
- `id_opcode` is purely combinational from the `id_instr` register.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `id_valid`=0, `id_instr`=32'h0000_0013 (NOP), `id_pc`=RESET_PC, `id_opcode`=7'b0010011, pc=RESET_PC, state=IDLE.
- Reset asserted mid-operation returns all state to these values immediately. Any later `imem_rvalid` is ignored until a new request is accepted.
- First request: `imem_req` rises in the 2nd cycle after `rst_n` deasserts.
- Latency: `imem_rvalid` in cycle N gives `id_valid`=1 in cycle N+1.
- Throughput: with zero-wait memory (ready=1, rvalid the cycle after) and `id_ready`=1, one instruction every 3 cycles (REQ, WAIT, HOLD).
- `id_instr`, `id_pc` and `id_valid` are stable while `id_valid && !id_ready`, unless a redirect occurs.
- Redirect in cycle N gives `id_valid`=0 in cycle N+1.

## Structure
- Shared package `rv32_pkg`:
  - opcode constants (OP_RTYPE 0110011, OP_ITYPE 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_LUI 0110111, OP_AUIPC 0010111, OP_JAL 1101111, OP_JALR 1100111);
  - NOP_INSTR = 32'h0000_0013;
  - fetch-state enum `fetch_state_t`.
- No sub-module. The FSM, PC register and output buffer are a single module.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory returning 0x00500093 at address 0 -> `imem_addr`=0 accepted; `id_valid`=1, `id_pc`=0, `id_instr`=0x00500093, `id_opcode`=0010011; next `imem_addr`=4.
- `id_ready` held low 5 cycles with the instruction in HOLD -> outputs stable; no `imem_req` issued; after release the next fetch address is pc+4.
- Redirect to 0x100 while in WAIT, stale rvalid 2 cycles later carrying 0xDEADBEEF -> stale data is never presented; next accepted `imem_addr`=0x100.
- Redirect to 0x203 in HOLD with coincident `id_ready` -> `id_valid` drops the next cycle; next `imem_addr`=0x200.
- PC at 0xFFFF_FFFC consumed -> next `imem_addr`=0x0000_0000.
- `rst_n` pulsed low while in WAIT -> outputs return to reset values asynchronously; a late rvalid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32_pkg.sv
// ============================================================================
// Module   : rv32_pkg
// Brief    : Shared RV32I definitions: opcodes, NOP encoding, fetch states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rv32_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : RV32I fetch stage: PC, single-outstanding imem fetch, decode buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_instr;
  logic [31:0]  r_id_pc;
  logic         w_load;
  logic [1:0]   w_unused_redirect_lsbs;

  assign w_unused_redirect_lsbs = redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_id_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_load) begin
        r_instr <= imem_rdata;
        r_id_pc <= r_pc;
      end
    end
  end

  // A redirect wins over every other event; the only thing that still matters
  // is whether the old request is left outstanding at the memory (-> DROP).
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    if (redirect_valid) begin
      w_pc_nxt = {redirect_pc[31:2], 2'b00};
      case (r_state)
        ST_IDLE: w_state_nxt = ST_REQ;
        ST_REQ:  w_state_nxt = imem_ready  ? ST_DROP : ST_REQ;
        ST_WAIT: w_state_nxt = imem_rvalid ? ST_REQ  : ST_DROP;
        ST_HOLD: w_state_nxt = ST_REQ;
        ST_DROP: w_state_nxt = imem_rvalid ? ST_REQ  : ST_DROP;
        default: w_state_nxt = ST_IDLE;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_REQ;
        ST_REQ: begin
          if (imem_ready) w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            w_load      = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (id_ready) begin
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) w_state_nxt = ST_REQ;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign imem_req  = (r_state == ST_REQ);
  assign imem_addr = r_pc;
  assign id_valid  = (r_state == ST_HOLD);
  assign id_instr  = r_instr;
  assign id_pc     = r_id_pc;
  assign id_opcode = r_instr[6:0];

endmodule

`default_nettype wire
